// File: rtl/serial_subtractor.sv
// Bit-serial A - B, LSB first, one registered borrow.
// Valid/ready on both sides; reports borrow, zero and signed overflow.
module serial_subtractor #(
  parameter int N = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] diff,
  output logic         bout,
  output logic         zero,
  output logic         ovf
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t state, state_n;

  logic [N-1:0]  a_sr, b_sr, res_sr, res_n;
  logic [CW-1:0] cnt;
  logic          br, br_n, d;
  logic          a_msb, b_msb;
  logic          last;

  assign d     = a_sr[0] ^ b_sr[0] ^ br;
  assign br_n  = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
  assign res_n = {d, res_sr[N-1:1]};
  assign last  = (cnt == CW'(N - 1));

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (in_valid && in_ready) state_n = SHIFT;
      SHIFT: if (last) state_n = DONE;
      DONE:  if (out_valid && out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Handshake flags track the state being entered, so they stay registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (state_n == IDLE);
      out_valid <= (state_n == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
      zero   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_sr  <= A;
            b_sr  <= B;
            a_msb <= A[N-1];
            b_msb <= B[N-1];
            br    <= 1'b0;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_n;
          br     <= br_n;
          cnt    <= cnt + 1'b1;
          if (last) begin
            diff <= res_n;
            bout <= br_n;
            zero <= (res_n == '0);
            ovf  <= (a_msb != b_msb) && (d != a_msb);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (N=6).
// Expected results queued at acceptance, compared while out_valid.
module tb_serial_subtractor;

  localparam int N = 6;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A, B;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] diff;
  logic         bout, zero, ovf;

  typedef struct packed {
    logic [N-1:0] diff;
    logic         bout;
    logic         zero;
    logic         ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  logic prev_ov = 1'b0;
  logic want_rdy = 1'b0;

  serial_subtractor #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .zero      (zero),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int a, input int b);
    exp_t e;
    int   sa, sb, sd;
    e.diff = 6'((a - b) & 63);
    e.bout = (a < b);
    e.zero = (e.diff == 0);
    sa = (a >= 32) ? a - 64 : a;
    sb = (b >= 32) ? b - 64 : b;
    sd = sa - sb;
    e.ovf = (sd > 31) || (sd < -32);
    return e;
  endfunction

  // Monitor: inputs change just after posedge, so negedge sees settled values.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      prev_ov  = 1'b0;
      want_rdy = 1'b0;
    end else begin
      if (want_rdy) begin
        check("in_ready_after_result", in_ready, 1);
        want_rdy = 1'b0;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(int'(A), int'(B)));
        acc_cyc = cyc;
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", out_valid, 0);
        end else begin
          if (!prev_ov)
            check("latency", cyc - acc_cyc, N + 1);
          check("diff", diff, exp_q[0].diff);
          check("bout", bout, exp_q[0].bout);
          check("zero", zero, exp_q[0].zero);
          check("ovf", ovf, exp_q[0].ovf);
          check("in_ready_busy", in_ready, 0);
          if (out_ready) begin
            void'(exp_q.pop_front());
            want_rdy = 1'b1;
          end
        end
      end
      prev_ov = out_valid;
    end
  end

  task automatic send(input int a, input int b);
    int n = 0;
    A = 6'(a);
    B = 6'(b);
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 50);
    if (!in_ready) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic check_zero_outs(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_diff"}, diff, 0);
    check({tag, "_flags"}, {bout, zero, ovf}, 0);
  endtask

  initial begin
    int n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    A         = '0;
    B         = '0;
    out_ready = 1'b1;

    repeat (3) begin
      @(negedge clk);
      check_zero_outs("reset");
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1 check("in_ready_pre_edge", in_ready, 0);
    @(posedge clk);
    #1 check("in_ready_post_edge", in_ready, 1);

    send(45, 18);
    drain();
    send(5, 9);
    drain();
    send(20, 20);
    drain();
    send(31, 32);
    drain();
    send(0, 63);
    drain();
    send(32, 1);
    drain();
    for (int i = 0; i < 6; i++) begin
      send($urandom_range(0, 63), $urandom_range(0, 63));
      drain();
    end

    // Backpressure: result 27 pending while a new request is offered.
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(45, 18);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("stall_out_valid_seen", out_valid, 1);
    @(posedge clk);
    #1 begin
      A = 6'd1;
      B = 6'd1;
      in_valid = 1'b1;
    end
    repeat (5) begin
      @(negedge clk);
      check("stall_out_valid", out_valid, 1);
      check("stall_diff", diff, 27);
      check("stall_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    // Abort an operation with reset in its third SHIFT cycle.
    A = 6'd10;
    B = 6'd3;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 50);
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_zero_outs("abort");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (N + 4) begin
      @(negedge clk);
      check("abort_no_out_valid", out_valid, 0);
    end
    check("abort_in_ready", in_ready, 1);

    send(5, 9);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
